// File: rtl/core_pipe_pkg.sv
// core_pipe_pkg: shared stage indices, forwarding codes, scoreboard entry and helpers for the pipeline sequencer
package core_pipe_pkg;
  localparam int IFID = 0;
  localparam int IDEX = 1;
  localparam int EXMEM = 2;
  localparam int MEMWB = 3;
  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;
  localparam int REG_AW = 5;
  typedef struct packed {
    logic valid;
    logic rd_we;
    logic isload;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } sb_t;
  typedef enum logic [2:0] {C_BUSY, C_REDIR, C_HAZ, C_IDLE, C_RUN} ctl_e;
  function automatic logic hit(sb_t e, logic [REG_AW-1:0] rs);
    return e.valid && e.rd_we && (e.rd != '0) && (e.rd == rs);
  endfunction
  // flush clears only the liveness bits; the remaining fields keep their old contents
  function automatic sb_t stage_nx(sb_t cur, sb_t prv, logic en, logic fl);
    sb_t r;
    r = (en && !fl) ? prv : cur;
    if (fl) begin
      r.valid = 1'b0;
      r.rd_we = 1'b0;
    end
    return r;
  endfunction
endpackage

// File: rtl/core_pipe_seq_if.sv
// core_pipe_seq_if: pipeline-control bundle between the RV32I datapath (master) and the sequencer (slave)
interface core_pipe_seq_if #(parameter int XLEN = 32, parameter int RAW = 5);
  logic if_valid;
  logic mem_busy;
  logic redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [RAW-1:0] id_rs1;
  logic [RAW-1:0] id_rs2;
  logic id_rs1_used;
  logic id_rs2_used;
  logic [RAW-1:0] id_rd;
  logic id_rd_we;
  logic id_isload;
  logic [XLEN-1:0] pc;
  logic pc_write;
  logic [3:0] stage_en;
  logic [3:0] stage_flush;
  logic [3:0] stage_valid;
  logic [1:0] fwd_sel1;
  logic [1:0] fwd_sel2;
  logic [RAW-1:0] wb_rd;
  logic wb_we;
  modport master (
    output if_valid, mem_busy, redirect, redirect_pc, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_isload,
    input  pc, pc_write, stage_en, stage_flush, stage_valid, fwd_sel1, fwd_sel2, wb_rd, wb_we
  );
  modport slave (
    input  if_valid, mem_busy, redirect, redirect_pc, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_isload,
    output pc, pc_write, stage_en, stage_flush, stage_valid, fwd_sel1, fwd_sel2, wb_rd, wb_we
  );
endinterface

// File: rtl/core_fwd_sel.sv
// core_fwd_sel: per-operand producer match against EX/MEM then MEM/WB (EX/MEM wins, x0 never matches)
module core_fwd_sel
  import core_pipe_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  sb_t               exmem,
  input  sb_t               memwb,
  output logic [1:0]        sel
);
  always_comb sel = hit(exmem, rs) ? FWD_EXMEM : hit(memwb, rs) ? FWD_MEMWB : FWD_REG;
endmodule

// File: rtl/core_pipe_seq.sv
// core_pipe_seq: PC owner, stage scoreboard, stall/flush/redirect priority and EX forwarding selects.
// CORE_FWD_EN: when defined, forward into EX and stall only on load-use; otherwise full interlock, selects tied to 0.
module core_pipe_seq
  import core_pipe_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              RAW      = 5,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input logic           clk,
  input logic           nrst,
  core_pipe_seq_if.slave bus
);
  logic [XLEN-1:0] pc;
  logic ifid_v;
  sb_t idex, exmem, memwb, id_e;
  ctl_e c;
  logic [3:0] en, fl;
  logic haz, pc_wr;
  logic [REG_AW-1:0] rs_a, rs_b;
  logic [1:0] s_a, s_b;
  assign id_e = '{valid: ifid_v, rd_we: bus.id_rd_we, isload: bus.id_isload, rd: REG_AW'(bus.id_rd),
                  rs1: REG_AW'(bus.id_rs1), rs2: REG_AW'(bus.id_rs2)};
  core_fwd_sel u_fwd_a (.rs(rs_a), .exmem(exmem), .memwb(memwb), .sel(s_a));
  core_fwd_sel u_fwd_b (.rs(rs_b), .exmem(exmem), .memwb(memwb), .sel(s_b));
`ifdef CORE_FWD_EN
  assign rs_a = idex.rs1;
  assign rs_b = idex.rs2;
  assign haz = idex.isload && ((bus.id_rs1_used && hit(idex, id_e.rs1)) || (bus.id_rs2_used && hit(idex, id_e.rs2)));
  assign bus.fwd_sel1 = s_a;
  assign bus.fwd_sel2 = s_b;
`else
  // without bypassing, the comparators watch the ID sources to find any pending producer
  assign rs_a = id_e.rs1;
  assign rs_b = id_e.rs2;
  assign haz = (bus.id_rs1_used && (hit(idex, rs_a) || s_a != FWD_REG)) ||
               (bus.id_rs2_used && (hit(idex, rs_b) || s_b != FWD_REG));
  assign bus.fwd_sel1 = FWD_REG;
  assign bus.fwd_sel2 = FWD_REG;
`endif
  always_comb begin
    c = bus.mem_busy ? C_BUSY : bus.redirect ? C_REDIR : haz ? C_HAZ : !bus.if_valid ? C_IDLE : C_RUN;
    en = 4'b1111;
    fl = 4'b0000;
    case (c)
      C_BUSY:  begin en = 4'b1000; fl = 4'b1000; end
      C_REDIR: begin en = 4'b1100; fl = 4'b0011; end
      C_HAZ:   begin en = 4'b1100; fl = 4'b0010; end
      C_IDLE:  begin en = 4'b1110; fl = 4'b0001; end
      default: ;
    endcase
    pc_wr = (c == C_REDIR) || (c == C_RUN);
  end
  assign bus.pc = pc;
  assign bus.pc_write = nrst && pc_wr;
  assign bus.stage_en = nrst ? en : 4'h0;
  assign bus.stage_flush = nrst ? fl : 4'hF;
  assign bus.stage_valid = {memwb.valid, exmem.valid, idex.valid, ifid_v};
  assign bus.wb_rd = RAW'(memwb.rd);
  assign bus.wb_we = memwb.valid && memwb.rd_we && (memwb.rd != '0);
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      pc <= RESET_PC;
      ifid_v <= 1'b0;
      idex <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      if (pc_wr) pc <= (c == C_REDIR) ? bus.redirect_pc : pc + XLEN'(PC_STEP);
      ifid_v <= fl[IFID] ? 1'b0 : en[IFID] ? 1'b1 : ifid_v;
      idex <= stage_nx(idex, id_e, en[IDEX], fl[IDEX]);
      exmem <= stage_nx(exmem, idex, en[EXMEM], fl[EXMEM]);
      memwb <= stage_nx(memwb, exmem, en[MEMWB], fl[MEMWB]);
    end
endmodule
